// File: rtl/waveform_analyzer_pkg.sv
// waveform_pkg: shape codes, FSM state type and default thresholds for waveform_analyzer
package waveform_pkg;
    localparam logic [1:0] SHAPE_SQUARE   = 2'b00;
    localparam logic [1:0] SHAPE_TRIANGLE = 2'b01;
    localparam logic [1:0] SHAPE_OTHER    = 2'b10;
    localparam logic [1:0] SHAPE_UNKNOWN  = 2'b11;
    localparam int         DEF_CNT_W      = 12;
    localparam logic [7:0] DEF_MID_TH     = 8'd64;
    localparam logic [7:0] DEF_LO_TH      = 8'd16;
    localparam logic [7:0] DEF_HI_TH      = 8'd240;
    localparam logic [7:0] DEF_SLOPE_MAX  = 8'd2;
    localparam logic [7:0] DEF_MIN_SWING  = 8'd32;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
endpackage

// File: rtl/waveform_analyzer_if.sv
// waveform_analyzer_if: sample stream in, per-period measurements out
// master: sample source / result consumer; slave: the analyzer
interface waveform_analyzer_if #(parameter int CNT_W = 12);
    logic [7:0]       sample_in;
    logic             sample_valid;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [7:0]       peak_max;
    logic [7:0]       peak_min;
    logic [1:0]       shape;
    logic             locked;
    logic             timeout;
    modport master(output sample_in, sample_valid,
                   input meas_valid, period, peak_max, peak_min, shape, locked, timeout);
    modport slave(input sample_in, sample_valid,
                  output meas_valid, period, peak_max, peak_min, shape, locked, timeout);
endinterface

// File: rtl/waveform_analyzer_classifier.sv
// wave_shape_classifier: per-period shape flags and shape decode
// i_start restarts flags with i_sample, i_update folds i_sample in; o_shape decodes the
// accumulated flags against the period swing i_max-i_min (combinational, latched by the top)
module wave_shape_classifier
    import waveform_pkg::*;
#(
    parameter logic [7:0] LO_TH     = DEF_LO_TH,
    parameter logic [7:0] HI_TH     = DEF_HI_TH,
    parameter logic [7:0] SLOPE_MAX = DEF_SLOPE_MAX,
    parameter logic [7:0] MIN_SWING = DEF_MIN_SWING
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_update,
    input  logic [7:0] i_sample,
    input  logic [7:0] i_prev,
    input  logic [7:0] i_max,
    input  logic [7:0] i_min,
    output logic [1:0] o_shape
);
    logic       r_rail_ok, r_saw_lo, r_saw_hi, r_slope_ok;
    logic [8:0] w_delta;
    logic       w_lo, w_hi, w_slope;
    logic [7:0] w_swing;
    always_comb begin
        w_delta = (i_sample >= i_prev) ? {1'b0, i_sample} - {1'b0, i_prev}
                                       : {1'b0, i_prev} - {1'b0, i_sample};
        w_lo    = i_sample <= LO_TH;
        w_hi    = i_sample >= HI_TH;
        w_slope = w_delta <= {1'b0, SLOPE_MAX};
        w_swing = i_max - i_min;
        o_shape = (w_swing < MIN_SWING)               ? SHAPE_UNKNOWN  :
                  (r_rail_ok && r_saw_lo && r_saw_hi) ? SHAPE_SQUARE   :
                  r_slope_ok                          ? SHAPE_TRIANGLE : SHAPE_OTHER;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rail_ok  <= 1'b1;
            r_saw_lo   <= 1'b0;
            r_saw_hi   <= 1'b0;
            r_slope_ok <= 1'b1;
        end else if (i_start) begin
            r_rail_ok  <= w_lo | w_hi;
            r_saw_lo   <= w_lo;
            r_saw_hi   <= w_hi;
            r_slope_ok <= w_slope;
        end else if (i_update) begin
            r_rail_ok  <= r_rail_ok & (w_lo | w_hi);
            r_saw_lo   <= r_saw_lo | w_lo;
            r_saw_hi   <= r_saw_hi | w_hi;
            r_slope_ok <= r_slope_ok & w_slope;
        end
    end
endmodule

// File: rtl/waveform_analyzer.sv
// waveform_analyzer: per-period length, min/max and shape of an 8-bit sample stream
// clk, rst (sync, active high); bus (slave): sample_in/sample_valid in,
// meas_valid/period/peak_max/peak_min/shape/locked/timeout out, all registered.
// Shape classification is built only with WAVEFORM_ANALYZER_CLASSIFY_EN; otherwise shape stays 2'b11.
module waveform_analyzer
    import waveform_pkg::*;
#(
    parameter int         CNT_W     = DEF_CNT_W,
    parameter logic [7:0] MID_TH    = DEF_MID_TH,
    parameter logic [7:0] LO_TH     = DEF_LO_TH,
    parameter logic [7:0] HI_TH     = DEF_HI_TH,
    parameter logic [7:0] SLOPE_MAX = DEF_SLOPE_MAX,
    parameter logic [7:0] MIN_SWING = DEF_MIN_SWING
) (
    input logic               clk,
    input logic               rst,
    waveform_analyzer_if.slave bus
);
    state_t           r_state;
    logic [7:0]       r_prev, r_max, r_min;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cross, w_start, w_update, w_sat;
    logic [1:0]       w_shape;
    always_comb begin
        w_cross  = bus.sample_valid && bus.sample_in >= MID_TH && r_prev < MID_TH;
        w_start  = w_cross && r_state != IDLE;
        w_update = bus.sample_valid && !w_cross && r_state == MEASURE;
        // the sample about to arrive would make the count all-ones
        w_sat    = r_cnt == {{(CNT_W-1){1'b1}}, 1'b0};
    end
`ifdef WAVEFORM_ANALYZER_CLASSIFY_EN
    wave_shape_classifier #(
        .LO_TH(LO_TH), .HI_TH(HI_TH), .SLOPE_MAX(SLOPE_MAX), .MIN_SWING(MIN_SWING)
    ) u_cls (
        .clk(clk), .rst(rst), .i_start(w_start), .i_update(w_update),
        .i_sample(bus.sample_in), .i_prev(r_prev), .i_max(r_max), .i_min(r_min),
        .o_shape(w_shape)
    );
`else
    assign w_shape = SHAPE_UNKNOWN;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_prev         <= 8'd0;
            r_cnt          <= '0;
            r_max          <= 8'd0;
            r_min          <= 8'hFF;
            bus.meas_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.locked     <= 1'b0;
            bus.period     <= '0;
            bus.peak_max   <= 8'd0;
            bus.peak_min   <= 8'hFF;
            bus.shape      <= SHAPE_UNKNOWN;
        end else begin
            bus.meas_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            if (bus.sample_valid) begin
                r_prev <= bus.sample_in;
                if (r_state == IDLE) begin
                    r_state <= ARM;
                end else if (w_start) begin
                    // closing crossing publishes, then opens the next period
                    if (r_state == MEASURE) begin
                        bus.period     <= r_cnt;
                        bus.peak_max   <= r_max;
                        bus.peak_min   <= r_min;
                        bus.shape      <= w_shape;
                        bus.meas_valid <= 1'b1;
                        bus.locked     <= 1'b1;
                    end
                    r_state <= MEASURE;
                    r_cnt   <= CNT_W'(1);
                    r_max   <= bus.sample_in;
                    r_min   <= bus.sample_in;
                end else if (r_state == MEASURE) begin
                    if (w_sat) begin
                        bus.timeout <= 1'b1;
                        bus.locked  <= 1'b0;
                        r_state     <= ARM;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_max <= (bus.sample_in > r_max) ? bus.sample_in : r_max;
                    r_min <= (bus.sample_in < r_min) ? bus.sample_in : r_min;
                end
            end
        end
    end
endmodule

// File: doc/waveform_analyzer.md
# waveform_analyzer

Receive-side companion to the function generator: consumes an 8-bit sample stream, such as the generator's square, triangle and reciprocal outputs, and measures it. Per period it reports the period length in valid samples, the min and max sample, and the waveform shape. Shape codes match the generator's `sel` encoding. Sits after the sample source, and its results feed display and self-check logic.

## Interface
Parameters:
- `CNT_W`, default 12: width of the period counter and `period` output.
- `MID_TH`, default 8'd64: rising-crossing threshold.
- `LO_TH`, default 8'd16: low rail band, where sample ≤ `LO_TH`.
- `HI_TH`, default 8'd240: high rail band, where sample ≥ `HI_TH`.
- `SLOPE_MAX`, default 8'd2: max |delta| between consecutive samples for a triangle.
- `MIN_SWING`, default 8'd32: minimum max−min for a classifiable waveform.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_in` in 8: unsigned sample.
- `sample_valid` in 1: sample qualifier.
- `meas_valid` out 1: one-cycle pulse; results updated.
- `period` out CNT_W: valid samples in the last complete period.
- `peak_max` out 8: max sample of the last period.
- `peak_min` out 8: min sample of the last period.
- `shape` out 2: 00 square, 01 triangle, 10 other/reciprocal, 11 unknown.
- `locked` out 1: at least one complete period measured since the last reset or timeout.
- `timeout` out 1: one-cycle pulse when the period counter saturates.

## Operation
- Only cycles with `sample_valid`=1 advance any state. All other cycles hold every register, and the pulses are 0.
- A rising crossing is a valid sample ≥ `MID_TH` whose previous valid sample was < `MID_TH`.
- The previous-sample register updates on every valid sample in every state, and resets to 0.
- FSM states:
  - IDLE: after reset. The first valid sample loads the previous-sample register and moves to ARM.
  - ARM: waits for a rising crossing. On a crossing, go to MEASURE and start accumulating with that sample (count=1, min=max=sample, flags initialised).
  - MEASURE: each valid non-crossing sample increments the count and updates min/max and the classification flags.
    - On a crossing: publish the results, pulse `meas_valid`, set `locked`, and restart accumulation with the crossing sample. State stays MEASURE.
    - On count reaching 2^CNT_W−1 without a crossing: pulse `timeout`, clear `locked`, go to ARM. Published results are retained.
- The crossing sample always belongs to the new period. Its delta from the previous sample counts toward the new period.
- Classification flags per period:
  - `rail_ok`: all samples are in the low or high band.
  - `saw_lo` / `saw_hi`: at least one sample was seen in each band.
  - `slope_ok`: every |delta| ≤ `SLOPE_MAX`. Delta is computed 9-bit, no wrap.
- Shape at publish, first match wins:
  - max−min < `MIN_SWING` → 11
  - `rail_ok` & `saw_lo` & `saw_hi` → 00
  - `slope_ok` → 01
  - otherwise → 10
- Reset values:
  - `meas_valid`, `timeout`, `locked`: 0
  - `period`: 0
  - `peak_max`: 0
  - `peak_min`: 8'hFF
  - `shape`: 2'b11
  - FSM: IDLE
- `rst` mid-period discards the partial accumulation with no publish.

## Timing
- All outputs are registered.
- `meas_valid` rises in the cycle after the clock edge that samples the closing crossing, so latency is 1 cycle. `period`, `peak_*` and `shape` change in that same cycle and are stable until the next publish.
- `timeout` has the same 1-cycle latency relative to the saturating sample.
- `meas_valid` and `timeout` are mutually exclusive, because a crossing takes priority at saturation.
- `rst` has priority over `sample_valid`.

## Configuration
- Macro: `WAVEFORM_ANALYZER_CLASSIFY_EN`.
- Defined: classification flags and the shape logic are built as described above.
- Undefined: no flag or delta logic is built, and `shape` is constantly 2'b11. Period, peaks, `locked` and `timeout` are unchanged.

## Structure
- Package `waveform_pkg` holds:
  - shape codes `SHAPE_SQUARE`=2'b00, `SHAPE_TRIANGLE`=2'b01, `SHAPE_OTHER`=2'b10, `SHAPE_UNKNOWN`=2'b11;
  - the FSM state typedef (IDLE, ARM, MEASURE);
  - default threshold constants.
- Sub-module `wave_shape_classifier` holds the flag accumulation and final shape decode. It is instantiated only under `WAVEFORM_ANALYZER_CLASSIFY_EN`.

## Test plan
- Square, generator sel=00 (128×0 then 128×255, continuous) → after the 2nd crossing, `meas_valid` pulses; `period`=256, `peak_min`=0, `peak_max`=255, `shape`=00, `locked`=1.
- Triangle, sel=01 (0..127, 127..0) → `period`=256, max=127, min=0, `shape`=01.
- Reciprocal, sel=10 (255/(255−n) sequence) → `period`=256, max=255, `shape`=10. With the macro undefined, `shape`=11 and `period` is still 256.
- Constant 8'd100 for 5000 valid samples after one crossing → `timeout` pulses at count 4095, `locked`=0, previously published values held.
- Square with `sample_valid` low on every other cycle → `period`=256. Assert `rst` mid-period → all outputs return to reset values, and the next publish occurs only after two new crossings.
- Flat 8'd70/8'd60 alternating (swing 10) → each crossing publishes `period`=2, `shape`=11.
